// File: rtl/hdmi_clk_pkg.sv
// Shared types and constants for the HDMI video-clock mode controller:
// FSM states, PLL config-port addresses and the per-mode divider table.
package hdmi_clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WRITE,
    ST_RELEASE,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  localparam logic [1:0] CFG_ADDR_MDIV  = 2'd0;
  localparam logic [1:0] CFG_ADDR_ODIV0 = 2'd1;
  localparam logic [1:0] CFG_ADDR_ODIV1 = 2'd2;

  typedef struct packed {
    logic [7:0] mdiv;
    logic [7:0] odiv0;
    logic [7:0] odiv1;
  } div_cfg_t;

  // Mode ids: 0 = 480p, 1 = 720p, 2 = 1080p, 3 = 1080p30; others read as zero.
  function automatic div_cfg_t mode_div(input int mode);
    case (mode)
      0:       return '{mdiv: 8'h36, odiv0: 8'h0A, odiv1: 8'h02};
      1:       return '{mdiv: 8'h4A, odiv0: 8'h05, odiv1: 8'h01};
      2:       return '{mdiv: 8'h6F, odiv0: 8'h04, odiv1: 8'h01};
      3:       return '{mdiv: 8'h6F, odiv0: 8'h08, odiv1: 8'h02};
      default: return '0;
    endcase
  endfunction

  function automatic logic [7:0] cfg_byte(input int mode, input logic [1:0] addr);
    div_cfg_t cfg;
    cfg = mode_div(mode);
    case (addr)
      CFG_ADDR_MDIV:  return cfg.mdiv;
      CFG_ADDR_ODIV0: return cfg.odiv0;
      CFG_ADDR_ODIV1: return cfg.odiv1;
      default:        return '0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hdmi_clk_mode_ctrl.sv
// HDMI video-clock mode controller: holds the PLL in reset, programs its
// dividers for the selected mode, qualifies lock and releases the video domain.
module hdmi_clk_mode_ctrl
  import hdmi_clk_pkg::*;
#(
  parameter int NUM_MODES     = 4,
  parameter int MODE_W        = $clog2(NUM_MODES),
  parameter int BOOT_MODE     = 1,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_req_valid,
  input  logic [MODE_W-1:0] mode_req_id,
  output logic              mode_req_ready,
  input  logic              pll_lock,
  output logic              pll_rst,
  output logic              cfg_wr_en,
  output logic [1:0]        cfg_addr,
  output logic [7:0]        cfg_data,
  input  logic              cfg_ack,
  output logic              video_rst_n,
  output logic [MODE_W-1:0] cur_mode,
  output logic              status_locked,
  output logic              status_err
);

  localparam int CNT_MAX_HL = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_HL > STABLE_CYCLES) ? CNT_MAX_HL : STABLE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int RETRY_W    = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);
  localparam logic [RETRY_W-1:0] RETRY_SAT   = RETRY_W'(MAX_RETRY);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [1:0]          wr_idx_q, wr_idx_d;
  logic                wr_gap_q, wr_gap_d;
  logic [MODE_W-1:0]   target_q, target_d;
  logic [MODE_W-1:0]   cur_mode_q, cur_mode_d;
  logic                err_q, err_d;
  logic                err_pulse_q, err_pulse_d;
  logic                lock_s;
  logic                req_acc;
  logic                req_ok;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  assign mode_req_ready = state_q inside {ST_RUN, ST_FAULT};
  assign req_acc        = mode_req_valid && mode_req_ready;
  assign req_ok         = int'(mode_req_id) < NUM_MODES;
  assign cnt_inc        = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    retry_d     = retry_q;
    wr_idx_d    = wr_idx_q;
    wr_gap_d    = wr_gap_q;
    target_d    = target_q;
    cur_mode_d  = cur_mode_q;
    err_d       = err_q;
    err_pulse_d = req_acc && !req_ok;

    case (state_q)
      ST_IDLE: begin
        state_d  = ST_HOLD;
        target_d = MODE_W'(BOOT_MODE);
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d  = ST_WRITE;
          wr_idx_d = CFG_ADDR_MDIV;
          wr_gap_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (wr_gap_q) begin
          wr_gap_d = 1'b0;
        end else if (cfg_ack) begin
          if (wr_idx_q == CFG_ADDR_ODIV1) begin
            state_d = ST_RELEASE;
          end else begin
            wr_idx_d = wr_idx_q + 2'd1;
            wr_gap_d = 1'b1;
          end
        end
      end
      ST_RELEASE: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          retry_d = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);
          if (retry_q >= RETRY_LAST) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d    = ST_RUN;
          retry_d    = '0;
          cur_mode_d = target_q;
        end
      end
      ST_RUN, ST_FAULT: begin
        // A valid request outranks a simultaneous lock loss.
        if (req_acc && req_ok) begin
          state_d  = ST_HOLD;
          target_d = mode_req_id;
          retry_d  = '0;
          err_d    = 1'b0;
        end else if (state_q == ST_RUN && !lock_s) begin
          state_d = ST_HOLD;
        end
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      wr_idx_q    <= '0;
      wr_gap_q    <= 1'b0;
      target_q    <= '0;
      cur_mode_q  <= '0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      wr_idx_q    <= wr_idx_d;
      wr_gap_q    <= wr_gap_d;
      target_q    <= target_d;
      cur_mode_q  <= cur_mode_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign pll_rst       = state_q inside {ST_IDLE, ST_HOLD, ST_WRITE, ST_FAULT};
  assign video_rst_n   = (state_q == ST_RUN);
  assign status_locked = (state_q == ST_RUN);
  assign cfg_wr_en     = (state_q == ST_WRITE) && !wr_gap_q;
  assign cfg_addr      = cfg_wr_en ? wr_idx_q : 2'd0;
  assign cfg_data      = cfg_wr_en ? cfg_byte(int'(target_q), wr_idx_q) : 8'd0;
  assign cur_mode      = cur_mode_q;
  assign status_err    = err_q | err_pulse_q;

endmodule
